// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the shift_sched scheduler and its shifter.
package shift_sched_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/shift_sched_if.sv
// Request/response bundle between two clients, the shift_sched block and its consumer.
interface shift_sched_if;
  import shift_sched_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [AMT_W-1:0]  req0_amt;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [AMT_W-1:0]  req1_amt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  req_id_t           rsp_id;

  modport master (
    output req0_valid, req0_data, req0_amt,
    output req1_valid, req1_data, req1_amt,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_data, req0_amt,
    input  req1_valid, req1_data, req1_amt,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id,
    input  rsp_ready
  );

endinterface

// File: rtl/shift_sched_barrelshifter.sv
// barrelshifter: combinational 8-bit rotate-left by 0..7.
module barrelshifter
  import shift_sched_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  b,
  output logic [DATA_W-1:0] out
);

  logic [2*DATA_W-1:0] dbl_s;

  // Shifting a doubled copy left puts the rotated byte in the upper half.
  always_comb begin
    dbl_s = {a, a} << b;
    out   = dbl_s[2*DATA_W-1:DATA_W];
  end

endmodule

// File: rtl/shift_sched.sv
// shift_sched: round-robin sharing of one rotate-left shifter between two requesters.
// Optional saturating grant counters are enabled by SHIFT_SCHED_STATS_EN.
module shift_sched
  import shift_sched_pkg::*;
`ifdef SHIFT_SCHED_STATS_EN
  #(parameter int CNT_W = 16)
`endif
(
  input  logic         clk,
  input  logic         rst_n,
  shift_sched_if.slave bus,
  output logic         busy
`ifdef SHIFT_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt0_cnt,
  output logic [CNT_W-1:0] gnt1_cnt
`endif
);

  state_t            state_q, state_d;
  req_id_t           last_gnt_q, last_gnt_d;
  logic [DATA_W-1:0] op_data_q, op_data_d;
  logic [AMT_W-1:0]  op_amt_q, op_amt_d;
  req_id_t           op_id_q, op_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  req_id_t           rsp_id_q, rsp_id_d;
  logic              gnt0_s, gnt1_s;
  logic [DATA_W-1:0] shift_out_s;

  barrelshifter u_shifter (
    .a   (op_data_q),
    .b   (op_amt_q),
    .out (shift_out_s)
  );

  // State, operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      op_data_q   <= {DATA_W{1'b0}};
      op_amt_q    <= {AMT_W{1'b0}};
      op_id_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DATA_W{1'b0}};
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      op_data_q   <= op_data_d;
      op_amt_q    <= op_amt_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // Arbitration and next-state logic; a tie goes to the requester not granted last.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    op_data_d   = op_data_q;
    op_amt_d    = op_amt_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid && (!bus.req1_valid || (last_gnt_q == 1'b1))) begin
          gnt0_s     = 1'b1;
          op_data_d  = bus.req0_data;
          op_amt_d   = bus.req0_amt;
          op_id_d    = 1'b0;
          last_gnt_d = 1'b0;
          state_d    = EXEC;
        end else if (bus.req1_valid) begin
          gnt1_s     = 1'b1;
          op_data_d  = bus.req1_data;
          op_amt_d   = bus.req1_amt;
          op_id_d    = 1'b1;
          last_gnt_d = 1'b1;
          state_d    = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_data_d  = shift_out_s;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  assign bus.req0_ready = gnt0_s;
  assign bus.req1_ready = gnt1_s;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
  assign busy           = (state_q != IDLE);

`ifdef SHIFT_SCHED_STATS_EN
  logic [CNT_W-1:0] gnt0_cnt_q, gnt1_cnt_q;

  // Saturating per-requester grant counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_cnt_q <= {CNT_W{1'b0}};
      gnt1_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (gnt0_s && (gnt0_cnt_q != {CNT_W{1'b1}})) begin
        gnt0_cnt_q <= gnt0_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        gnt0_cnt_q <= gnt0_cnt_q;
      end
      if (gnt1_s && (gnt1_cnt_q != {CNT_W{1'b1}})) begin
        gnt1_cnt_q <= gnt1_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        gnt1_cnt_q <= gnt1_cnt_q;
      end
    end
  end

  assign gnt0_cnt = gnt0_cnt_q;
  assign gnt1_cnt = gnt1_cnt_q;
`endif

endmodule
